// File: rtl/io_ctrl_pkg.sv
// Shared constants for the board I/O controller: default bus addresses,
// read-FSM states and the hex-to-seven-segment table.
package io_ctrl_pkg;

    localparam logic [31:0] IN_ADDR_DEF  = 32'hFFFF_FC70;
    localparam logic [31:0] OUT_ADDR_DEF = 32'hFFFF_FC60;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_PRESS = 2'd1,
        DONE       = 2'd2
    } rd_state_e;

    // Segment order {a,b,c,d,e,f,g,dp}, active-high, dp always off
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises an asynchronous push-button, debounces it and emits a single
// cycle pulse on each debounced press.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_expire;

    assign w_differ = (r_sync2 != r_level);
    assign w_expire = w_differ && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Level follows the synchronised input only after an unbroken run of disagreement
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= w_expire && !r_level;
            if (w_expire) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else if (w_differ) begin
                r_cnt   <= r_cnt + 1'b1;
            end else begin
                r_cnt   <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/io_input_wait_ctrl.sv
// Memory-mapped switch/button/seven-segment controller: input loads stall the
// CPU until enter is pressed, display stores update a scanned 8-digit register.
module io_input_wait_ctrl
    import io_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned SCAN_DIV        = 4,
    parameter logic [31:0] IN_ADDR         = IN_ADDR_DEF,
    parameter logic [31:0] OUT_ADDR        = OUT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] switchInput,
    input  logic        enter,
    input  logic [31:0] mem_addr,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic [7:0]  tubSel,
    output logic [7:0]  seg_led1234,
    output logic [7:0]  seg_led5678
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    rd_state_e        r_state;
    rd_state_e        w_next;
    logic [15:0]      r_in;
    logic [31:0]      r_disp;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_idx;
    logic             w_press;
    logic             w_in_hit;
    logic             w_out_hit;
    logic             w_capture;
    logic [3:0]       w_left_nib;
    logic [3:0]       w_right_nib;
    logic [3:0]       w_onehot;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter_db (
        .clk    (clk),
        .reset  (reset),
        .i_btn  (enter),
        .o_press(w_press)
    );

    assign w_in_hit  = io_read  && (mem_addr == IN_ADDR);
    assign w_out_hit = io_write && (mem_addr == OUT_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Stall is raised in the same cycle as the load so the CPU never advances past it
    always_comb begin
        w_next    = r_state;
        stall     = 1'b0;
        read_data = '0;
        w_capture = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_in_hit) begin
                    stall  = 1'b1;
                    w_next = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                stall = 1'b1;
                if (w_press) begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end
            end
            DONE: begin
                read_data = {16'b0, r_in};
                w_next    = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in   <= '0;
            r_disp <= '0;
        end else begin
            if (w_capture) begin
                r_in <= switchInput;
            end
            if (w_out_hit) begin
                r_disp <= write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Index 0 drives the leftmost digit of each group with the most significant nibble
    always_comb begin
        w_left_nib  = r_disp[31:28];
        w_right_nib = r_disp[15:12];
        case (r_idx)
            2'd1: begin
                w_left_nib  = r_disp[27:24];
                w_right_nib = r_disp[11:8];
            end
            2'd2: begin
                w_left_nib  = r_disp[23:20];
                w_right_nib = r_disp[7:4];
            end
            2'd3: begin
                w_left_nib  = r_disp[19:16];
                w_right_nib = r_disp[3:0];
            end
            default: begin
                w_left_nib  = r_disp[31:28];
                w_right_nib = r_disp[15:12];
            end
        endcase
    end

    assign w_onehot    = 4'(4'b1000 >> r_idx);
    assign tubSel      = {w_onehot, w_onehot};
    assign seg_led1234 = hex_to_seg(w_left_nib);
    assign seg_led5678 = hex_to_seg(w_right_nib);

endmodule

// File: tb/tb_io_input_wait_ctrl.sv
// Self-checking bench for io_input_wait_ctrl with short debounce and scan periods.
module tb_io_input_wait_ctrl;

    localparam int unsigned DEB   = 4;
    localparam int unsigned SDIV  = 2;
    localparam logic [31:0] IN_A  = 32'hFFFF_FC70;
    localparam logic [31:0] OUT_A = 32'hFFFF_FC60;

    typedef struct packed {
        logic [7:0] tub;
        logic [7:0] lft;
        logic [7:0] rgt;
    } disp_t;

    logic        clk;
    logic        reset;
    logic [15:0] switchInput;
    logic        enter;
    logic [31:0] mem_addr;
    logic        io_read;
    logic        io_write;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic [7:0]  tubSel;
    logic [7:0]  seg_led1234;
    logic [7:0]  seg_led5678;

    int          n_checks;
    int          n_pass;
    logic [31:0] rd_q [$];
    disp_t       disp_q [$];

    io_input_wait_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .SCAN_DIV       (SDIV),
        .IN_ADDR        (IN_A),
        .OUT_ADDR       (OUT_A)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .switchInput(switchInput),
        .enter      (enter),
        .mem_addr   (mem_addr),
        .io_read    (io_read),
        .io_write   (io_write),
        .write_data (write_data),
        .read_data  (read_data),
        .stall      (stall),
        .tubSel     (tubSel),
        .seg_led1234(seg_led1234),
        .seg_led5678(seg_led5678)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            io_read  = 1'b0;
            io_write = 1'b0;
            enter    = 1'b0;
        end
    endtask

    // Leaves the bench at the negedge where reset is released
    task automatic apply_reset(input int n);
        step();
        reset    = 1'b1;
        io_read  = 1'b0;
        io_write = 1'b0;
        enter    = 1'b0;
        repeat (n) step();
        reset = 1'b0;
    endtask

    // Drives enter high for cycles start..start+len-1; returns the cycle stall first drops
    task automatic wait_done(input int start, input int len, output int done_c);
        done_c = 0;
        for (int c = 1; c <= 60; c++) begin
            step();
            enter = (c >= start) && (c < start + len);
            #1;
            if (stall === 1'b0) begin
                done_c = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset(2);
        #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else n_pass++;
        n_checks++; if (read_data !== 32'h0) $display("FAIL rst_rdata: got %h want 0", read_data); else n_pass++;
        n_checks++; if (tubSel !== 8'b1000_1000) $display("FAIL rst_tub: got %b want 10001000", tubSel); else n_pass++;
        n_checks++; if (seg_led1234 !== 8'hFC) $display("FAIL rst_seg1234: got %h want fc", seg_led1234); else n_pass++;
        n_checks++; if (seg_led5678 !== 8'hFC) $display("FAIL rst_seg5678: got %h want fc", seg_led5678); else n_pass++;
    endtask

    task automatic test_single_read();
        int          done_c;
        logic [31:0] exp;
        step();
        switchInput = 16'hA5C3;
        mem_addr    = IN_A;
        io_read     = 1'b1;
        rd_q.push_back(32'h0000_A5C3);
        #1;
        n_checks++; if (stall !== 1'b1) $display("FAIL rd_stall_same_cycle: got %b want 1", stall); else n_pass++;
        wait_done(5, 10, done_c);
        n_checks++;
        if (done_c < 5 + DEB || done_c > 5 + DEB + 6) $display("FAIL rd_latency: done cycle %0d want %0d..%0d", done_c, 5 + DEB, 5 + DEB + 6);
        else n_pass++;
        exp = rd_q.pop_front();
        n_checks++; if (read_data !== exp) $display("FAIL rd_data: got %h want %h", read_data, exp); else n_pass++;
        // io_read still high in DONE must not restart the read; enter remains held
        for (int c = done_c + 1; c <= 20; c++) begin
            step();
            io_read = 1'b0;
            enter   = (c < 15);
            #1;
            n_checks++; if (stall !== 1'b0) $display("FAIL rd_idle_stall: cycle %0d got %b want 0", c, stall); else n_pass++;
            n_checks++; if (read_data !== 32'h0) $display("FAIL rd_idle_rdata: cycle %0d got %h want 0", c, read_data); else n_pass++;
        end
        idle(10);
    endtask

    task automatic test_glitch();
        int          done_c;
        logic [31:0] exp;
        step();
        switchInput = 16'h3C5A;
        mem_addr    = IN_A;
        io_read     = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            enter = (c == 3) || (c == 4);
            #1;
            n_checks++; if (stall !== 1'b1) $display("FAIL glitch_stall: cycle %0d got %b want 1", c, stall); else n_pass++;
        end
        switchInput = 16'h0F0F;
        rd_q.push_back(32'h0000_0F0F);
        wait_done(1, 6, done_c);
        n_checks++;
        if (done_c < DEB + 2 || done_c > DEB + 8) $display("FAIL glitch_latency: done cycle %0d want %0d..%0d", done_c, DEB + 2, DEB + 8);
        else n_pass++;
        exp = rd_q.pop_front();
        n_checks++; if (read_data !== exp) $display("FAIL glitch_data: got %h want %h", read_data, exp); else n_pass++;
        step();
        io_read = 1'b0;
        enter   = 1'b0;
        idle(10);
    endtask

    task automatic test_back_to_back();
        int          done_c;
        logic [31:0] exp;
        step();
        switchInput = 16'h1111;
        mem_addr    = IN_A;
        io_read     = 1'b1;
        rd_q.push_back(32'h0000_1111);
        wait_done(1, 1000, done_c);
        n_checks++; if (done_c == 0) $display("FAIL b2b_first_timeout: stall %b want 0", stall); else n_pass++;
        exp = rd_q.pop_front();
        n_checks++; if (read_data !== exp) $display("FAIL b2b_first_data: got %h want %h", read_data, exp); else n_pass++;
        step();
        io_read = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL b2b_gap_stall: got %b want 0", stall); else n_pass++;
        step();
        switchInput = 16'h2222;
        io_read     = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b1) $display("FAIL b2b_second_stall: got %b want 1", stall); else n_pass++;
        // Enter still held from the first read: must not complete the second
        for (int c = 1; c <= 15; c++) begin
            step();
            #1;
            n_checks++; if (stall !== 1'b1) $display("FAIL b2b_held_stall: cycle %0d got %b want 1", c, stall); else n_pass++;
        end
        for (int c = 1; c <= 8; c++) begin
            step();
            enter       = 1'b0;
            switchInput = 16'h6789;
            #1;
            n_checks++; if (stall !== 1'b1) $display("FAIL b2b_release_stall: cycle %0d got %b want 1", c, stall); else n_pass++;
        end
        rd_q.push_back(32'h0000_6789);
        wait_done(1, 6, done_c);
        n_checks++;
        if (done_c < DEB + 2 || done_c > DEB + 8) $display("FAIL b2b_latency: done cycle %0d want %0d..%0d", done_c, DEB + 2, DEB + 8);
        else n_pass++;
        exp = rd_q.pop_front();
        n_checks++; if (read_data !== exp) $display("FAIL b2b_second_data: got %h want %h", read_data, exp); else n_pass++;
        step();
        io_read = 1'b0;
        enter   = 1'b0;
        idle(10);
    endtask

    task automatic test_display();
        logic [7:0] tub_t [4];
        logic [7:0] lft_t [4];
        logic [7:0] rgt_t [4];
        int         pat   [10];
        disp_t      e;
        tub_t = '{8'h88, 8'h44, 8'h22, 8'h11};
        lft_t = '{8'h60, 8'hDA, 8'hF2, 8'h66};
        rgt_t = '{8'hEE, 8'h3E, 8'h9C, 8'h7A};
        pat   = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 1};
        apply_reset(1);
        mem_addr   = OUT_A;
        io_write   = 1'b1;
        write_data = 32'h1234_ABCD;
        for (int k = 0; k < 10; k++)
            disp_q.push_back(disp_t'{tub: tub_t[pat[k]], lft: lft_t[pat[k]], rgt: rgt_t[pat[k]]});
        for (int k = 0; k < 10; k++) begin
            step();
            io_write = 1'b0;
            io_read  = (k == 3);
            mem_addr = OUT_A;
            if (k == 7) begin
                io_write   = 1'b1;
                mem_addr   = OUT_A + 32'd4;
                write_data = 32'hFFFF_FFFF;
            end
            #1;
            e = disp_q.pop_front();
            n_checks++; if (tubSel !== e.tub) $display("FAIL disp_tub: step %0d got %h want %h", k, tubSel, e.tub); else n_pass++;
            n_checks++; if (seg_led1234 !== e.lft) $display("FAIL disp_left: step %0d got %h want %h", k, seg_led1234, e.lft); else n_pass++;
            n_checks++; if (seg_led5678 !== e.rgt) $display("FAIL disp_right: step %0d got %h want %h", k, seg_led5678, e.rgt); else n_pass++;
            if (k == 3) begin
                n_checks++; if (stall !== 1'b0) $display("FAIL other_read_stall: got %b want 0", stall); else n_pass++;
                n_checks++; if (read_data !== 32'h0) $display("FAIL other_read_data: got %h want 0", read_data); else n_pass++;
            end
        end
        idle(4);
    endtask

    task automatic test_reset_mid_wait();
        apply_reset(1);
        mem_addr    = IN_A;
        io_read     = 1'b1;
        switchInput = 16'hBEEF;
        #1;
        n_checks++; if (stall !== 1'b1) $display("FAIL rmw_enter_wait: got %b want 1", stall); else n_pass++;
        step();
        io_read    = 1'b0;
        io_write   = 1'b1;
        mem_addr   = OUT_A;
        write_data = 32'h9F00_0000;
        #1;
        n_checks++; if (stall !== 1'b1) $display("FAIL rmw_write_stall: got %b want 1", stall); else n_pass++;
        step();
        io_write = 1'b0;
        mem_addr = IN_A;
        io_read  = 1'b1;
        #1;
        n_checks++; if (tubSel !== 8'h44) $display("FAIL rmw_tub: got %h want 44", tubSel); else n_pass++;
        n_checks++; if (seg_led1234 !== 8'h8E) $display("FAIL rmw_write_during_stall: got %h want 8e", seg_led1234); else n_pass++;
        n_checks++; if (seg_led5678 !== 8'hFC) $display("FAIL rmw_right: got %h want fc", seg_led5678); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            step();
            #1;
            n_checks++; if (stall !== 1'b1) $display("FAIL rmw_wait_stall: cycle %0d got %b want 1", c, stall); else n_pass++;
        end
        step();
        reset   = 1'b1;
        io_read = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b1) $display("FAIL rmw_pre_reset_stall: got %b want 1", stall); else n_pass++;
        step();
        reset = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL rmw_post_reset_stall: got %b want 0", stall); else n_pass++;
        n_checks++; if (read_data !== 32'h0) $display("FAIL rmw_post_reset_rdata: got %h want 0", read_data); else n_pass++;
        n_checks++; if (tubSel !== 8'h88) $display("FAIL rmw_post_reset_tub: got %h want 88", tubSel); else n_pass++;
        n_checks++; if (seg_led1234 !== 8'hFC) $display("FAIL rmw_disp_cleared_l: got %h want fc", seg_led1234); else n_pass++;
        n_checks++; if (seg_led5678 !== 8'hFC) $display("FAIL rmw_disp_cleared_r: got %h want fc", seg_led5678); else n_pass++;
        for (int c = 1; c <= 20; c++) begin
            step();
            enter = (c <= 8);
            #1;
            n_checks++;
            if ({stall, read_data} !== 33'h0) $display("FAIL rmw_press_no_read: cycle %0d stall %b rdata %h want 0/0", c, stall, read_data);
            else n_pass++;
        end
        idle(4);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        reset       = 1'b1;
        switchInput = 16'h0;
        enter       = 1'b0;
        mem_addr    = 32'h0;
        io_read     = 1'b0;
        io_write    = 1'b0;
        write_data  = 32'h0;
        test_reset();
        test_single_read();
        test_glitch();
        test_back_to_back();
        test_display();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
